// File: rtl/sonuc_bcd.sv
// +----------------------------------------------------------------------------+
// | sonuc_bcd : signed 32.32 fixed-point to sign + 10.4 BCD digit converter     |
// | Optional: SONUC_BCD_SIFIR_BASTIR_EN blanks leading integer zeros (4'hF)     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sonuc_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        basla,
  input  logic [63:0] sonuc,
  input  logic        tasma,
  output logic        hazir,
  output logic        gecerli,
  output logic        isaret,
  output logic [39:0] tam_bcd,
  output logic [15:0] kusurat_bcd,
  output logic        hata
);

  localparam logic [1:0] BOS     = 2'd0;
  localparam logic [1:0] TAM     = 2'd1;
  localparam logic [1:0] KUSURAT = 2'd2;
  localparam logic [1:0] BITTI   = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_int_sr;
  logic [31:0] r_frac;
  logic [39:0] r_bcd;
  logic [15:0] r_kus;
  logic        r_isaret;
  logic        r_hata;

  logic [63:0] w_mag;
  logic [39:0] w_adj;
  logic [35:0] w_f10;
  logic [39:0] w_tam_out;

  assign w_mag = sonuc[63] ? (~sonuc + 64'd1) : sonuc;
  assign w_f10 = ({4'd0, r_frac} << 3) + ({4'd0, r_frac} << 1);
  assign hazir = (r_state == BOS);

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5)
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

`ifdef SONUC_BCD_SIFIR_BASTIR_EN
  // Blank zeros from the top down until the first non-zero digit; digit 0 always shown.
  always_comb begin
    logic lead;
    w_tam_out = r_bcd;
    lead      = 1'b1;
    for (int i = 9; i > 0; i--) begin
      if (lead && (r_bcd[i*4 +: 4] == 4'd0))
        w_tam_out[i*4 +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb begin
    w_tam_out = r_bcd;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOS;
      r_cnt       <= 6'd0;
      r_int_sr    <= 32'd0;
      r_frac      <= 32'd0;
      r_bcd       <= 40'd0;
      r_kus       <= 16'd0;
      r_isaret    <= 1'b0;
      r_hata      <= 1'b0;
      gecerli     <= 1'b0;
      isaret      <= 1'b0;
      tam_bcd     <= 40'd0;
      kusurat_bcd <= 16'd0;
      hata        <= 1'b0;
    end else begin
      gecerli <= 1'b0;
      case (r_state)
        BOS: begin
          if (basla) begin
            r_int_sr <= w_mag[63:32];
            r_frac   <= w_mag[31:0];
            r_isaret <= sonuc[63];
            r_hata   <= tasma;
            r_bcd    <= 40'd0;
            r_kus    <= 16'd0;
            r_cnt    <= 6'd0;
            r_state  <= TAM;
          end
        end
        TAM: begin
          r_bcd    <= {w_adj[38:0], r_int_sr[31]};
          r_int_sr <= {r_int_sr[30:0], 1'b0};
          if (r_cnt == 6'd31) begin
            r_cnt   <= 6'd0;
            r_state <= KUSURAT;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        KUSURAT: begin
          // Each x10 step pushes the next decimal digit in from the right.
          r_kus  <= {r_kus[11:0], w_f10[35:32]};
          r_frac <= w_f10[31:0];
          if (r_cnt == 6'd3) begin
            r_cnt   <= 6'd0;
            r_state <= BITTI;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        BITTI: begin
          tam_bcd     <= w_tam_out;
          kusurat_bcd <= r_kus;
          isaret      <= r_isaret;
          hata        <= r_hata;
          gecerli     <= 1'b1;
          r_state     <= BOS;
        end
        default: r_state <= BOS;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sonuc_bcd.sv
// +----------------------------------------------------------------------------+
// | tb_sonuc_bcd : scoreboard bench for sonuc_bcd                               |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sonuc_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        basla;
  logic [63:0] sonuc;
  logic        tasma;
  logic        hazir;
  logic        gecerli;
  logic        isaret;
  logic [39:0] tam_bcd;
  logic [15:0] kusurat_bcd;
  logic        hata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pulses = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_exp;

  sonuc_bcd u_dut (
    .clk         (clk),
    .rst         (rst),
    .basla       (basla),
    .sonuc       (sonuc),
    .tasma       (tasma),
    .hazir       (hazir),
    .gecerli     (gecerli),
    .isaret      (isaret),
    .tam_bcd     (tam_bcd),
    .kusurat_bcd (kusurat_bcd),
    .hata        (hata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: decimal digits by divide/modulo, fraction by repeated x10.
  function automatic logic [63:0] model(input logic [63:0] s, input logic t);
    logic [63:0] mag;
    logic [31:0] ip;
    logic [63:0] fr;
    logic [39:0] tb;
    logic [15:0] kb;
    logic        lead;
    mag = s[63] ? (~s + 64'd1) : s;
    ip  = mag[63:32];
    fr  = {32'd0, mag[31:0]};
    for (int i = 0; i < 10; i++) begin
      tb[i*4 +: 4] = 4'(ip % 10);
      ip = ip / 10;
    end
    for (int i = 3; i >= 0; i--) begin
      fr = fr * 10;
      kb[i*4 +: 4] = fr[35:32];
      fr = {32'd0, fr[31:0]};
    end
`ifdef SONUC_BCD_SIFIR_BASTIR_EN
    lead = 1'b1;
    for (int i = 9; i > 0; i--) begin
      if (lead && tb[i*4 +: 4] == 4'd0) tb[i*4 +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return {6'd0, s[63], t, tb, kb};
  endfunction

  function automatic logic [63:0] outs();
    return {6'd0, isaret, hata, tam_bcd, kusurat_bcd};
  endfunction

  always @(posedge clk) begin
    #1;
    if (gecerli) begin
      n_pulses++;
      if (sb_q.size() == 0) check_val("spurious_gecerli", 64'd1, 64'd0);
      else check_val("result", outs(), sb_q.pop_front());
    end
  end

  // The edge that samples basla is edge 1; gecerli must first be seen after edge 38.
  task automatic run_conv(input logic [63:0] s, input logic t, input bit second_basla);
    int n;
    int p0;
    p0 = n_pulses;
    @(negedge clk);
    sonuc = s;
    tasma = t;
    basla = 1'b1;
    last_exp = model(s, t);
    sb_q.push_back(last_exp);
    @(posedge clk);
    #1;
    basla = 1'b0;
    sonuc = {$urandom, $urandom};
    tasma = ~t;
    n = 1;
    check_val("hazir_busy", {63'd0, hazir}, 64'd0);
    while (!gecerli && n < 60) begin
      @(negedge clk);
      basla = second_basla && (n == 4);
      @(posedge clk);
      #1;
      n++;
      if (n == 20) check_val("hazir_mid", {63'd0, hazir}, 64'd0);
    end
    basla = 1'b0;
    check_val("latency", 64'(n), 64'd38);
    check_val("hazir_with_gecerli", {63'd0, hazir}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("hold", outs(), last_exp);
    if (second_basla) begin
      repeat (40) @(posedge clk);
      #1;
      check_val("single_pulse", 64'(n_pulses - p0), 64'd1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    basla = 1'b0;
    sonuc = 64'd0;
    tasma = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outs", outs(), 64'd0);
    check_val("reset_hazir", {62'd0, hazir, gecerli}, 64'd2);
    @(negedge clk);
    rst = 1'b0;

    run_conv(64'h0000_0003_8000_0000, 1'b0, 1'b0);
    run_conv(64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    run_conv(64'h0000_0000_D76A_A478, 1'b0, 1'b0);
    run_conv(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_conv(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    run_conv(64'h0000_0000_8000_0000, 1'b0, 1'b0);
    run_conv(64'h0000_0003_8000_0000, 1'b1, 1'b0);
    run_conv(64'h0001_E240_4000_0000, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) run_conv({$urandom, $urandom}, 1'($urandom), 1'b0);

    // Reset on edge 10 of a conversion aborts it and clears the outputs.
    begin
      int p0;
      p0 = n_pulses;
      @(negedge clk);
      sonuc = 64'h0000_0042_1000_0000;
      basla = 1'b1;
      @(posedge clk);
      #1;
      basla = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("abort_hazir", {63'd0, hazir}, 64'd1);
      check_val("abort_outs", outs(), 64'd0);
      repeat (45) @(posedge clk);
      #1;
      check_val("abort_no_pulse", 64'(n_pulses - p0), 64'd0);
    end

    // rst wins over a simultaneous basla.
    begin
      int p0;
      p0 = n_pulses;
      @(negedge clk);
      rst   = 1'b1;
      basla = 1'b1;
      sonuc = 64'h0000_0005_0000_0000;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      basla = 1'b0;
      check_val("rst_priority_hazir", {63'd0, hazir}, 64'd1);
      repeat (45) @(posedge clk);
      #1;
      check_val("rst_priority_no_pulse", 64'(n_pulses - p0), 64'd0);
    end

    run_conv(64'h0000_0009_0000_0001, 1'b1, 1'b0);
    check_val("queue_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sonuc_bcd.md
SONUC_BCD -- requirements
Module: sonuc_bcd

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 basla  input  1  start request; sampled only in state BOS.
REQ-005 sonuc  input  64  signed two's-complement 32.32 fixed-point result from the sinus stage.
REQ-006 tasma  input  1  overflow flag from the upstream stage.
REQ-007 hazir  output  1  high when state is BOS.
REQ-008 gecerli  output  1  one-cycle pulse marking new outputs.
REQ-009 isaret  output  1  1 when the captured sonuc is negative.
REQ-010 tam_bcd  output  40  ten BCD digits of the integer part; most significant digit in [39:36].
REQ-011 kusurat_bcd  output  16  four BCD digits of the fraction, truncated; first decimal place in [15:12].
REQ-012 hata  output  1  tasma as captured for this conversion.

Function
REQ-013 The state machine SHALL have states BOS, TAM, KUSURAT and BITTI, all registered.
REQ-014 In BOS with basla=1 at an edge, the block SHALL do all of the following on that edge:
- capture |sonuc| as a 64-bit two's-complement negation when sonuc[63]=1;
- capture isaret and hata;
- clear the digit accumulators;
- go to TAM.
REQ-015 TAM SHALL run 32 cycles of double-dabble, one integer bit per cycle, MSB first: add 3 to every digit >=5, then shift left. It SHALL use a 6-bit counter and go to KUSURAT after the 32nd shift.
REQ-016 KUSURAT SHALL run 4 cycles. Each cycle: f*10 = (f<<3)+(f<<1) in 36 bits, digit = bits [35:32], f = bits [31:0]. The four digits fill [15:12] down to [3:0].
REQ-017 BITTI SHALL last 1 cycle and then return to BOS. On the edge that leaves BITTI, the block SHALL register tam_bcd, kusurat_bcd, isaret and hata, and assert gecerli for exactly one cycle.
REQ-018 Latency from the edge that samples basla to the first cycle with gecerli=1 SHALL be 38 edges.
REQ-019 hazir SHALL be 0 from the edge after basla is sampled until the edge on which gecerli rises; it rises together with gecerli.
REQ-020 basla while hazir=0 SHALL be ignored: no queueing and no restart.
REQ-021 Outputs SHALL hold their last values between gecerli pulses.
REQ-022 tasma=1 SHALL still produce a full conversion with the same latency, with hata=1.
REQ-023 For sonuc=0x8000_0000_0000_0000, the magnitude 2^31 fits unsigned 32 bits and SHALL yield 2147483648.0000.
REQ-024 Input changes after capture SHALL NOT affect the conversion in progress.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter BOS and clear all outputs to 0 except hazir, which is set to 1.
REQ-026 Reset mid-conversion SHALL abort the conversion with no gecerli pulse.
REQ-027 rst SHALL take priority over a simultaneous basla.

Configuration
REQ-028 With macro SONUC_BCD_SIFIR_BASTIR_EN defined, leading zero digits of tam_bcd SHALL be replaced by 4'hF (blank) when registered in BITTI. Digit [3:0] is never blanked.
REQ-029 Without SONUC_BCD_SIFIR_BASTIR_EN, all ten integer digits SHALL be output as plain BCD.
REQ-030 Latency and handshake SHALL be identical in both configurations.

Verification
REQ-031 Reset then basla with sonuc=0x0000_0003_8000_0000, tasma=0 -> gecerli at edge 38, tam_bcd=0x0000000003, kusurat_bcd=0x5000, isaret=0, hata=0.
REQ-032 sonuc=0xFFFF_FFFF_8000_0000 -> isaret=1, tam_bcd=0x0000000000, kusurat_bcd=0x5000.
REQ-033 sonuc=0x0000_0000_D76A_A478 -> kusurat_bcd=0x8414, isaret=0.
REQ-034 Cover both extremes:
- sonuc=0x7FFF_FFFF_FFFF_FFFF -> tam_bcd=0x2147483647, kusurat_bcd=0x9999;
- sonuc=0x8000_0000_0000_0000 -> isaret=1, tam_bcd=0x2147483648, kusurat_bcd=0x0000.
REQ-035 Reset and handshake corner cases:
- basla, then rst at edge 10 -> no gecerli, hazir=1, outputs 0;
- a second basla at edge 5 -> ignored, single gecerli at edge 38.
REQ-036 With SONUC_BCD_SIFIR_BASTIR_EN, 3.5 -> tam_bcd=0xFFFFFFFFF3; 0.5 -> tam_bcd=0xFFFFFFFFF0; tasma=1 -> hata=1 with normal digits.
